// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor: SEG_W bits per stage, WIDTH/SEG_W register stages.
// hold freezes every register; data registers load only on valid, so outputs hold across bubbles.
module pipe_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             hold,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned L = WIDTH / SEG_W;

  // Per-stage registers: a_q/b_q keep the (effective) operands, sum_q the slices added so far.
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] b_q   [L];
  logic [WIDTH-1:0] sum_q [L];
  logic [L-1:0]     carry_q;
  logic [L-1:0]     valid_q;
  logic             ovf_q;

  // Stage inputs and next-state values.
  logic [WIDTH-1:0] op_a  [L];
  logic [WIDTH-1:0] op_b  [L];
  logic [WIDTH-1:0] op_s  [L];
  logic [WIDTH-1:0] nxt_s [L];
  logic [L-1:0]     op_c;
  logic [L-1:0]     op_v;
  logic [L-1:0]     nxt_c;
  logic             ovf_d;

  always_comb begin
    op_a[0] = a;
    op_b[0] = sub ? ~b : b;
    op_s[0] = '0;
    op_c[0] = cin ^ sub;
    op_v[0] = in_valid;
    for (int k = 1; k < L; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_s[k] = sum_q[k-1];
      op_c[k] = carry_q[k-1];
      op_v[k] = valid_q[k-1];
    end

    for (int k = 0; k < L; k++) begin
      logic [SEG_W-1:0] seg_a;
      logic [SEG_W-1:0] seg_b;
      logic [SEG_W:0]   seg;
      seg_a    = SEG_W'(op_a[k] >> (k * SEG_W));
      seg_b    = SEG_W'(op_b[k] >> (k * SEG_W));
      seg      = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, op_c[k]};
      nxt_c[k] = seg[SEG_W];
      // Upper slices of op_s are still zero, so OR-ing in the new slice is enough.
      nxt_s[k] = op_s[k] | (WIDTH'(seg[SEG_W-1:0]) << (k * SEG_W));
    end

    ovf_d = (1'(op_a[L-1] >> (WIDTH-1)) == 1'(op_b[L-1] >> (WIDTH-1))) &&
            (1'(nxt_s[L-1] >> (WIDTH-1)) != 1'(op_a[L-1] >> (WIDTH-1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!hold) begin
      valid_q <= op_v;
      for (int k = 0; k < L; k++) begin
        if (op_v[k]) begin
          a_q[k]     <= op_a[k];
          b_q[k]     <= op_b[k];
          sum_q[k]   <= nxt_s[k];
          carry_q[k] <= nxt_c[k];
        end
      end
      if (op_v[L-1]) ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[L-1];
  assign s         = sum_q[L-1];
  assign cout      = carry_q[L-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=8, SEG_W=4): directed vectors plus random traffic
// against an arithmetic reference fed through an L-deep delay line.
module tb_pipe_adder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEG_W = 4;
  localparam int unsigned L     = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub, hold;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout, ovf;

  pipe_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .hold      (hold),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: results computed at accept time, then delayed L cycles.
  logic             pv [L];
  logic [WIDTH-1:0] ps [L];
  logic             pc [L];
  logic             po [L];
  logic             exp_v, exp_c, exp_o;
  logic [WIDTH-1:0] exp_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic ref_calc(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input logic isub,
                          output logic [WIDTH-1:0] rs, output logic rc, output logic ro);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    if (!isub) begin
      ur = ua + ub + int'(ic);
      rc = (ur > 255);
      sr = sa + sb + int'(ic);
    end else begin
      ur = ua - ub - int'(ic);
      rc = (ua >= ub + int'(ic));
      sr = sa - sb - int'(ic);
    end
    rs = WIDTH'(ur & 255);
    ro = (sr > 127) || (sr < -128);
  endtask

  task automatic clear_model();
    for (int k = 0; k < L; k++) begin
      pv[k] = 1'b0; ps[k] = '0; pc[k] = 1'b0; po[k] = 1'b0;
    end
    exp_v = 1'b0; exp_s = '0; exp_c = 1'b0; exp_o = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
    check({tag, ".s"},         32'(s),         32'(exp_s));
    check({tag, ".cout"},      32'(cout),      32'(exp_c));
    check({tag, ".ovf"},       32'(ovf),       32'(exp_o));
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, then compare.
  task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] ia,
                      input logic [WIDTH-1:0] ib, input logic ic, input logic isub,
                      input logic ih);
    logic [WIDTH-1:0] rs;
    logic             rc, ro;
    in_valid = iv; a = ia; b = ib; cin = ic; sub = isub; hold = ih;
    @(posedge clk);
    if (!ih) begin
      for (int k = L - 1; k > 0; k--) begin
        pv[k] = pv[k-1]; ps[k] = ps[k-1]; pc[k] = pc[k-1]; po[k] = po[k-1];
      end
      ref_calc(ia, ib, ic, isub, rs, rc, ro);
      pv[0] = iv; ps[0] = rs; pc[0] = rc; po[0] = ro;
      exp_v = pv[L-1];
      if (pv[L-1]) begin
        exp_s = ps[L-1]; exp_c = pc[L-1]; exp_o = po[L-1];
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; hold = 1'b0;
    clear_model();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    compare_all("post_reset");

    // Directed arithmetic vectors.
    step("add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    idle("add_ff_01_out");
    check("add_ff_01_valid", 32'(out_valid), 32'd1);
    check("add_ff_01_s",     32'(s),         32'h00);
    check("add_ff_01_cout",  32'(cout),      32'd1);
    check("add_ff_01_ovf",   32'(ovf),       32'd0);
    idle("gap0");
    check("bubble_valid", 32'(out_valid), 32'd0);
    check("bubble_hold_s", 32'(s), 32'h00);

    step("add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    idle("add_7f_01_out");
    check("add_7f_01_s",    32'(s),    32'h80);
    check("add_7f_01_cout", 32'(cout), 32'd0);
    check("add_7f_01_ovf",  32'(ovf),  32'd1);

    step("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    idle("sub_05_07_out");
    check("sub_05_07_s",    32'(s),    32'hFE);
    check("sub_05_07_cout", 32'(cout), 32'd0);
    check("sub_05_07_ovf",  32'(ovf),  32'd0);

    step("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    idle("sub_80_01_out");
    check("sub_80_01_s",    32'(s),    32'h7F);
    check("sub_80_01_cout", 32'(cout), 32'd1);
    check("sub_80_01_ovf",  32'(ovf),  32'd1);
    idle("gap1");

    // Stream with one hold cycle after the second transaction.
    step("str_a", 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    step("str_b", 1'b1, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b0);
    check("str_out1_s", 32'(s), 32'h30);
    check("str_out1_v", 32'(out_valid), 32'd1);
    step("str_hold", 1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    check("str_hold_s", 32'(s), 32'h30);
    step("str_c", 1'b1, 8'hF0, 8'h10, 1'b0, 1'b0, 1'b0);
    check("str_out2_s",    32'(s),    32'h11);
    check("str_out2_cout", 32'(cout), 32'd0);
    idle("str_drain");
    check("str_out3_s",    32'(s),    32'h00);
    check("str_out3_cout", 32'(cout), 32'd1);
    check("str_out3_v",    32'(out_valid), 32'd1);
    idle("str_end");
    check("str_end_v", 32'(out_valid), 32'd0);

    // Reset mid-operation, asserted between edges.
    step("rst_t1", 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    step("rst_t2", 1'b1, 8'h56, 8'h78, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_async_v", 32'(out_valid), 32'd0);
    check("rst_async_s", 32'(s), 32'h00);
    compare_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle("rst_release");
    step("rst_new", 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    idle("rst_new_out");
    check("rst_new_s", 32'(s), 32'h03);

    // Random regression.
    for (int i = 0; i < 10000; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
